// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the PRBS checker: FSM state encoding, the
// XAPP052 XNOR tap table and the feedback helper used by the predictor.
package lfsr_checker_pkg;

    localparam int unsigned MAX_BITS = 20;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_HUNT = 2'd1,
        ST_LOCK = 2'd2
    } state_e;

    // Tap positions (1-based) for maximal-length XNOR LFSRs of length 3..20.
    function automatic logic [MAX_BITS:1] tap_mask(input int unsigned n);
        logic [MAX_BITS:1] m;
        m = '0;
        case (n)
            3:  begin m[3]  = 1'b1; m[2]  = 1'b1; end
            4:  begin m[4]  = 1'b1; m[3]  = 1'b1; end
            5:  begin m[5]  = 1'b1; m[3]  = 1'b1; end
            6:  begin m[6]  = 1'b1; m[5]  = 1'b1; end
            7:  begin m[7]  = 1'b1; m[6]  = 1'b1; end
            8:  begin m[8]  = 1'b1; m[6]  = 1'b1; m[5] = 1'b1; m[4] = 1'b1; end
            9:  begin m[9]  = 1'b1; m[5]  = 1'b1; end
            10: begin m[10] = 1'b1; m[7]  = 1'b1; end
            11: begin m[11] = 1'b1; m[9]  = 1'b1; end
            12: begin m[12] = 1'b1; m[6]  = 1'b1; m[4] = 1'b1; m[1] = 1'b1; end
            13: begin m[13] = 1'b1; m[4]  = 1'b1; m[3] = 1'b1; m[1] = 1'b1; end
            14: begin m[14] = 1'b1; m[5]  = 1'b1; m[3] = 1'b1; m[1] = 1'b1; end
            15: begin m[15] = 1'b1; m[14] = 1'b1; end
            16: begin m[16] = 1'b1; m[15] = 1'b1; m[13] = 1'b1; m[4] = 1'b1; end
            17: begin m[17] = 1'b1; m[14] = 1'b1; end
            18: begin m[18] = 1'b1; m[11] = 1'b1; end
            19: begin m[19] = 1'b1; m[6]  = 1'b1; m[2] = 1'b1; m[1] = 1'b1; end
            20: begin m[20] = 1'b1; m[17] = 1'b1; end
            default: m = '0;
        endcase
        return m;
    endfunction

    // Every table entry has an even tap count, so the XNOR chain reduces
    // to the inverted XOR of the tapped bits.
    function automatic logic xnor_fb(input int unsigned n, input logic [MAX_BITS:1] s);
        return ~(^(s & tap_mask(n)));
    endfunction

endpackage

// File: rtl/lfsr_checker_fb.sv
// lfsr_fb: combinational predictor of the next PRBS bit.
//   i_state   : current LFSR contents, bit 1 is the newest bit
//   o_pred_c  : XNOR feedback bit, i.e. the expected next received bit
module lfsr_fb
    import lfsr_checker_pkg::*;
#(
    parameter int unsigned NUM_BITS = 20
) (
    input  logic [NUM_BITS:1] i_state,
    output logic              o_pred_c
);

    assign o_pred_c = xnor_fb(NUM_BITS, MAX_BITS'(i_state));

endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising PRBS checker for XNOR LFSR sequences.
//   clk, rst_n  : clock (rising edge), async active-low reset
//   i_valid     : i_bit is sampled this cycle
//   i_bit       : received serial PRBS bit
//   i_clear     : clears the error and bit counters
//   o_locked    : checker is locked to the incoming sequence
//   o_err       : one-cycle pulse per mismatched bit while locked
//   o_err_cnt   : saturating mismatch count while locked
//   o_bit_cnt   : saturating checked-bit count while locked
//   o_state     : current FSM state (SYNC=0, HUNT=1, LOCK=2)
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int unsigned NUM_BITS    = 20,
    parameter int unsigned LOCK_CNT    = 32,
    parameter int unsigned UNLOCK_ERRS = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_bit_cnt,
    output logic [1:0]       o_state
);

    localparam int unsigned FILL_W  = $clog2(NUM_BITS + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned CERR_W  = $clog2(UNLOCK_ERRS + 1);

    if (NUM_BITS < 3 || NUM_BITS > MAX_BITS) begin : g_bad_len
        $error("lfsr_checker: NUM_BITS out of range 3..20");
    end

    state_e              state_q,   state_d;
    logic [NUM_BITS:1]   shift_q,   shift_d;
    logic [FILL_W-1:0]   fill_q,    fill_d;
    logic [MATCH_W-1:0]  match_q,   match_d;
    logic [CERR_W-1:0]   cerr_q,    cerr_d;
    logic                locked_q,  locked_d;
    logic                err_q,     err_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    err_base_c, bit_base_c;
    logic                pred_c;

    lfsr_fb #(.NUM_BITS(NUM_BITS)) u_fb (
        .i_state  (shift_q),
        .o_pred_c (pred_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SYNC;
            shift_q   <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            cerr_q    <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            cerr_q    <= cerr_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next-state logic: fill, hunt for LOCK_CNT matches, then track errors.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        fill_d     = fill_q;
        match_d    = match_q;
        cerr_d     = cerr_q;
        err_d      = 1'b0;
        // Clear takes effect before any increment in the same cycle.
        err_base_c = i_clear ? '0 : err_cnt_q;
        bit_base_c = i_clear ? '0 : bit_cnt_q;
        err_cnt_d  = err_base_c;
        bit_cnt_d  = bit_base_c;

        if (i_valid) begin
            case (state_q)
                ST_SYNC: begin
                    shift_d = {shift_q[NUM_BITS-1:1], i_bit};
                    if (fill_q == FILL_W'(NUM_BITS - 1)) begin
                        fill_d = '0;
                        // All ones is the XNOR lockup state; refill instead.
                        if (!(&shift_d)) begin
                            state_d = ST_HUNT;
                            match_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                ST_HUNT: begin
                    shift_d = {shift_q[NUM_BITS-1:1], pred_c};
                    if (i_bit != pred_c) begin
                        state_d = ST_SYNC;
                        fill_d  = '0;
                        match_d = '0;
                    end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                        state_d = ST_LOCK;
                        match_d = '0;
                        cerr_d  = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end
                ST_LOCK: begin
                    shift_d   = {shift_q[NUM_BITS-1:1], pred_c};
                    bit_cnt_d = (&bit_base_c) ? bit_base_c : bit_base_c + 1'b1;
                    if (i_bit != pred_c) begin
                        err_d     = 1'b1;
                        err_cnt_d = (&err_base_c) ? err_base_c : err_base_c + 1'b1;
                        if (cerr_q == CERR_W'(UNLOCK_ERRS - 1)) begin
                            state_d = ST_SYNC;
                            fill_d  = '0;
                            cerr_d  = '0;
                        end else begin
                            cerr_d = cerr_q + 1'b1;
                        end
                    end else begin
                        cerr_d = '0;
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                    fill_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCK);
    end

    assign o_locked  = locked_q;
    assign o_err     = err_q;
    assign o_err_cnt = err_cnt_q;
    assign o_bit_cnt = bit_cnt_q;
    assign o_state   = state_q;

endmodule
